time_keeper_sched: RTL and testbench



---
 rtl/time_keeper_sched.sv | 169 ++++++++++++++++
 tb/tb_time_keeper_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/time_keeper_sched.sv
// Time-of-day and date registers with a one-field-per-cycle carry ripple
// driven by the 1 Hz tick, plus commit arbitration for key-control loads.
module time_keeper_sched #(
   parameter int YEAR_MAX = 99,
   parameter bit LEAP_EN  = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        TICK,
   input  logic        HOLD,
   input  logic        SET_REQ,
   input  logic [16:0] SET_TIME,
   input  logic [15:0] SET_DATE,
   output logic [16:0] TIME,
   output logic [15:0] DATE,
   output logic        BUSY,
   output logic        SET_ACK,
   output logic        SET_ERR,
   output logic        DAY_ROLL,
   output logic        TICK_DROP,
   output logic [2:0]  STATE_DBG
);

   // Handshake: there is no ready path back to the requesters. SET_REQ and
   // TICK are single-cycle valids that are always accepted; while BUSY they
   // are parked in one-deep pending slots, and SET_ACK/SET_ERR/TICK_DROP
   // report the outcome one cycle after the deciding edge.

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] R_SEC   = 3'd1;
   localparam logic [2:0] R_MIN   = 3'd2;
   localparam logic [2:0] R_HOUR  = 3'd3;
   localparam logic [2:0] R_DAY   = 3'd4;
   localparam logic [2:0] R_MONTH = 3'd5;
   localparam logic [2:0] R_YEAR  = 3'd6;

   localparam logic [6:0] YMAX = YEAR_MAX[6:0];

   logic [2:0]  state;
   logic [5:0]  sec, min;
   logic [4:0]  hour, day;
   logic [3:0]  month;
   logic [6:0]  year;

   logic        pend_set, pend_tick;
   logic [16:0] pend_time;
   logic [15:0] pend_date;

   logic [16:0] src_time;
   logic [15:0] src_date;
   logic        src_ok;

   function automatic logic [4:0] dim(input logic [3:0] m, input logic [6:0] y);
      logic [4:0] d;
      d = 5'd31;
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
         4'd2:                    d = (LEAP_EN && (y[1:0] == 2'd0)) ? 5'd29 : 5'd28;
         default:                 d = 5'd31;
      endcase
      return d;
   endfunction

   // A commit arriving this cycle takes precedence over the parked copy.
   always_comb begin
      src_time = SET_REQ ? SET_TIME : pend_time;
      src_date = SET_REQ ? SET_DATE : pend_date;
      src_ok   = (src_time[5:0] <= 6'd59) && (src_time[11:6] <= 6'd59) &&
                 (src_time[16:12] <= 5'd23) &&
                 (src_date[8:5] >= 4'd1) && (src_date[8:5] <= 4'd12) &&
                 (src_date[4:0] >= 5'd1) &&
                 (src_date[4:0] <= dim(src_date[8:5], src_date[15:9]));
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         sec       <= '0;
         min       <= '0;
         hour      <= '0;
         day       <= 5'd1;
         month     <= 4'd1;
         year      <= '0;
         pend_set  <= 1'b0;
         pend_tick <= 1'b0;
         pend_time <= '0;
         pend_date <= '0;
         SET_ACK   <= 1'b0;
         SET_ERR   <= 1'b0;
         DAY_ROLL  <= 1'b0;
         TICK_DROP <= 1'b0;
      end else begin
         SET_ACK   <= 1'b0;
         SET_ERR   <= 1'b0;
         DAY_ROLL  <= 1'b0;
         TICK_DROP <= 1'b0;
         if (state == IDLE) begin
            if (SET_REQ || pend_set) begin
               if (src_ok) begin
                  hour  <= src_time[16:12];
                  min   <= src_time[11:6];
                  sec   <= src_time[5:0];
                  year  <= src_date[15:9];
                  month <= src_date[8:5];
                  day   <= src_date[4:0];
               end
               SET_ACK   <= src_ok;
               SET_ERR   <= !src_ok;
               pend_set  <= 1'b0;
               pend_tick <= 1'b0;
            end else if ((TICK || pend_tick) && !HOLD) begin
               state     <= R_SEC;
               pend_tick <= 1'b0;
            end
         end else begin
            if (SET_REQ) begin
               pend_set  <= 1'b1;
               pend_time <= SET_TIME;
               pend_date <= SET_DATE;
            end
            if (TICK && !HOLD) begin
               if (pend_tick) TICK_DROP <= 1'b1;
               else           pend_tick <= 1'b1;
            end
            // Each field either wraps and hands the carry on, or ends the ripple.
            case (state)
               R_SEC: begin
                  if (sec == 6'd59) begin sec <= '0; state <= R_MIN; end
                  else begin sec <= sec + 6'd1; state <= IDLE; end
               end
               R_MIN: begin
                  if (min == 6'd59) begin min <= '0; state <= R_HOUR; end
                  else begin min <= min + 6'd1; state <= IDLE; end
               end
               R_HOUR: begin
                  if (hour == 5'd23) begin
                     hour     <= '0;
                     DAY_ROLL <= 1'b1;
                     state    <= R_DAY;
                  end else begin
                     hour  <= hour + 5'd1;
                     state <= IDLE;
                  end
               end
               R_DAY: begin
                  if (day == dim(month, year)) begin day <= 5'd1; state <= R_MONTH; end
                  else begin day <= day + 5'd1; state <= IDLE; end
               end
               R_MONTH: begin
                  if (month == 4'd12) begin month <= 4'd1; state <= R_YEAR; end
                  else begin month <= month + 4'd1; state <= IDLE; end
               end
               R_YEAR: begin
                  if (year == YMAX) year <= '0;
                  else              year <= year + 7'd1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign TIME      = {hour, min, sec};
   assign DATE      = {year, month, day};
   assign BUSY      = (state != IDLE);
   assign STATE_DBG = state;

endmodule

// File: tb/tb_time_keeper_sched.sv
// Directed bench for time_keeper_sched: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_time_keeper_sched;

   logic        CLK = 1'b0;
   logic        RESET, TICK, HOLD, SET_REQ;
   logic [16:0] SET_TIME;
   logic [15:0] SET_DATE;
   logic [16:0] TIME;
   logic [15:0] DATE;
   logic        BUSY, SET_ACK, SET_ERR, DAY_ROLL, TICK_DROP;
   logic [2:0]  STATE_DBG;

   int total = 0;
   int bad   = 0;
   int busy_cnt, roll_cnt;

   time_keeper_sched #(.YEAR_MAX(99), .LEAP_EN(1'b1)) dut (
      .CLK(CLK), .RESET(RESET), .TICK(TICK), .HOLD(HOLD), .SET_REQ(SET_REQ),
      .SET_TIME(SET_TIME), .SET_DATE(SET_DATE), .TIME(TIME), .DATE(DATE),
      .BUSY(BUSY), .SET_ACK(SET_ACK), .SET_ERR(SET_ERR), .DAY_ROLL(DAY_ROLL),
      .TICK_DROP(TICK_DROP), .STATE_DBG(STATE_DBG)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic commit(input logic [16:0] t, input logic [15:0] d, input logic tk);
      SET_REQ  = 1'b1;
      SET_TIME = t;
      SET_DATE = d;
      TICK     = tk;
      cyc();
      SET_REQ  = 1'b0;
      TICK     = 1'b0;
   endtask

   // Pulse TICK once, then count BUSY cycles and DAY_ROLL pulses until idle.
   task automatic tick_and_wait();
      TICK = 1'b1;
      cyc();
      TICK = 1'b0;
      busy_cnt = 0;
      roll_cnt = 0;
      for (int i = 0; i < 20 && BUSY; i++) begin
         busy_cnt++;
         if (DAY_ROLL) roll_cnt++;
         cyc();
      end
      if (DAY_ROLL) roll_cnt++;
      check("ripple_done", {31'd0, BUSY}, 32'd0);
   endtask

   initial begin
      RESET = 1'b1; TICK = 1'b0; HOLD = 1'b0; SET_REQ = 1'b0;
      SET_TIME = '0; SET_DATE = '0;
      cyc(); cyc();
      RESET = 1'b0;

      // Reset state held with no inputs
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("rst_time", {15'd0, TIME}, 32'h0);
         check("rst_date", {16'd0, DATE}, 32'h0021);
         check("rst_busy", {31'd0, BUSY}, 32'd0);
         check("rst_pulses", {28'd0, SET_ACK, SET_ERR, DAY_ROLL, TICK_DROP}, 32'd0);
      end

      // Full ripple: 23:59:59 99/12/31 -> 00:00:00 0/1/1
      commit(17'h17EFB, 16'hC79F, 1'b0);
      check("full_ack", {31'd0, SET_ACK}, 32'd1);
      check("full_time_loaded", {15'd0, TIME}, 32'h17EFB);
      tick_and_wait();
      check("full_busy_cycles", busy_cnt, 32'd6);
      check("full_roll_count", roll_cnt, 32'd1);
      check("full_time", {15'd0, TIME}, 32'h0);
      check("full_date", {16'd0, DATE}, 32'h0021);

      // Leap year 24: Feb 28 -> Feb 29
      commit(17'h17EFB, 16'h305C, 1'b0);
      tick_and_wait();
      check("leap_date", {16'd0, DATE}, 32'h305D);
      check("leap_time", {15'd0, TIME}, 32'h0);

      // Non-leap year 23: Feb 28 -> Mar 1
      commit(17'h17EFB, 16'h2E5C, 1'b0);
      tick_and_wait();
      check("nonleap_date", {16'd0, DATE}, 32'h2E61);

      // Commit during ripple is parked and applied on the first idle cycle
      commit(17'h00EFB, 16'h2E61, 1'b0);
      TICK = 1'b1;
      cyc();
      TICK = 1'b0;
      check("pend_busy1", {29'd0, STATE_DBG}, 32'd1);
      cyc();
      check("pend_busy2", {31'd0, BUSY}, 32'd1);
      SET_REQ = 1'b1; SET_TIME = 17'h0C8B8; SET_DATE = 16'h2E61;
      cyc();
      SET_REQ = 1'b0;
      check("pend_no_early_ack", {31'd0, SET_ACK}, 32'd0);
      cyc();
      check("pend_idle", {31'd0, BUSY}, 32'd0);
      check("pend_ripple_result", {15'd0, TIME}, 32'h01000);
      cyc();
      check("pend_ack", {31'd0, SET_ACK}, 32'd1);
      check("pend_time", {15'd0, TIME}, 32'h0C8B8);
      cyc();
      check("pend_ack_once", {31'd0, SET_ACK}, 32'd0);

      // Invalid commit: April 31
      commit(17'h01083, 16'h2E9F, 1'b0);
      check("err_pulse", {31'd0, SET_ERR}, 32'd1);
      check("err_no_ack", {31'd0, SET_ACK}, 32'd0);
      check("err_time", {15'd0, TIME}, 32'h0C8B8);
      check("err_date", {16'd0, DATE}, 32'h2E61);
      cyc();
      check("err_once", {31'd0, SET_ERR}, 32'd0);

      // HOLD: ticks are ignored entirely
      HOLD = 1'b1;
      for (int i = 0; i < 5; i++) begin
         TICK = 1'b1;
         cyc();
         TICK = 1'b0;
         cyc();
         check("hold_busy", {31'd0, BUSY}, 32'd0);
         check("hold_drop", {31'd0, TICK_DROP}, 32'd0);
      end
      check("hold_time", {15'd0, TIME}, 32'h0C8B8);
      HOLD = 1'b0;
      cyc();
      check("hold_release_idle", {31'd0, BUSY}, 32'd0);

      // Commit with a simultaneous tick: the tick is discarded
      commit(17'h01EFB, 16'h2E61, 1'b1);
      check("commit_tick_time", {15'd0, TIME}, 32'h01EFB);
      check("commit_tick_busy", {31'd0, BUSY}, 32'd0);
      cyc();
      check("commit_tick_still_idle", {31'd0, BUSY}, 32'd0);

      // Tick pending plus a dropped tick during a three-field ripple
      TICK = 1'b1;
      cyc();
      check("drop_r_sec", {29'd0, STATE_DBG}, 32'd1);
      cyc();
      TICK = 1'b0;
      check("drop_none_yet1", {31'd0, TICK_DROP}, 32'd0);
      cyc();
      TICK = 1'b1;
      check("drop_none_yet2", {31'd0, TICK_DROP}, 32'd0);
      cyc();
      TICK = 1'b0;
      check("drop_pulse", {31'd0, TICK_DROP}, 32'd1);
      check("drop_first_ripple_time", {15'd0, TIME}, 32'h02000);
      check("drop_idle", {31'd0, BUSY}, 32'd0);
      cyc();
      check("drop_once", {31'd0, TICK_DROP}, 32'd0);
      check("drop_pending_started", {31'd0, BUSY}, 32'd1);
      cyc();
      check("drop_final_time", {15'd0, TIME}, 32'h02001);
      check("drop_final_idle", {31'd0, BUSY}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
